// File: rtl/led_pkg.sv
// Shared definitions for the LED flash controller: debounce state encoding and
// default timing parameters.
package led_pkg;

   typedef enum logic [1:0] {
      REL   = 2'd0,
      PWAIT = 2'd1,
      PRS   = 2'd2,
      RWAIT = 2'd3
   } deb_state_e;

   localparam int unsigned DEB_CYCLES_DEF = 16;
   localparam int unsigned TICK_DIV_DEF   = 8;

endpackage

// File: rtl/led_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM; produces the
// accepted level and a registered one-cycle strobe on each accepted rise.
module led_debounce
   import led_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   deb_state_e    r_state;
   deb_state_e    w_state_d;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_d;
   logic          r_rise;
   logic          w_rise_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= REL;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_rise  <= w_rise_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_rise_d  = 1'b0;
      unique case (r_state)
         REL: begin
            if (r_sync2) begin
               w_state_d = PWAIT;
               w_cnt_d   = '0;
            end
         end
         PWAIT: begin
            if (!r_sync2) begin
               w_state_d = REL;
            end else if (r_cnt == CNT_MAX) begin
               w_state_d = PRS;
               w_rise_d  = 1'b1;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         PRS: begin
            if (!r_sync2) begin
               w_state_d = RWAIT;
               w_cnt_d   = '0;
            end
         end
         RWAIT: begin
            if (r_sync2) begin
               w_state_d = PRS;
            end else if (r_cnt == CNT_MAX) begin
               w_state_d = REL;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: w_state_d = REL;
      endcase
   end

   // RWAIT still counts as pressed until the release is confirmed.
   assign o_level = (r_state == PRS) || (r_state == RWAIT);
   assign o_rise  = r_rise;

endmodule

// File: rtl/led_flash_ctrl.sv
// LED flash control front end: debounced key strobe, debounced mode select and
// a flash-rate prescaler whose phase realigns to every accepted key press.
module led_flash_ctrl
   import led_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned TICK_DIV   = TICK_DIV_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic KEY_IN,
   input  logic SEL_IN,
   output logic KEY_P,
   output logic SEL_OUT,
   output logic TICK
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic          w_key_rise;
   logic          w_key_level;
   logic          w_sel_level;
   logic          w_sel_rise_unused;
   logic [PW-1:0] r_pre;
   logic [PW-1:0] w_pre_d;
   logic          w_tick_d;
   logic          r_key_p;
   logic          r_sel_out;
   logic          r_tick;

   led_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_deb (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_raw   (KEY_IN),
      .o_level (w_key_level),
      .o_rise  (w_key_rise)
   );

   led_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sel_deb (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_raw   (SEL_IN),
      .o_level (w_sel_level),
      .o_rise  (w_sel_rise_unused)
   );

   // The load happens on the edge that raises KEY_P, so the count reads 0
   // during the KEY_P cycle and a coinciding wrap loses its TICK.
   always_comb begin
      w_pre_d  = r_pre + PW'(1);
      w_tick_d = 1'b0;
      if (w_key_rise) begin
         w_pre_d = '0;
      end else if (r_pre == PRE_MAX) begin
         w_pre_d  = '0;
         w_tick_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pre     <= '0;
         r_key_p   <= 1'b0;
         r_sel_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_pre     <= w_pre_d;
         r_key_p   <= w_key_rise & w_key_level;
         r_sel_out <= w_sel_level;
         r_tick    <= w_tick_d;
      end
   end

   assign KEY_P   = r_key_p;
   assign SEL_OUT = r_sel_out;
   assign TICK    = r_tick;

endmodule

// File: doc/led_flash_ctrl.md
LED_FLASH_CTRL -- requirements
Module: led_flash_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16, number of stable synchronized samples required to accept a level change; legal values are 1 or greater.
REQ-002 Parameter TICK_DIV, default 8, period of TICK in CLK cycles; legal values are 2 or greater.
REQ-003 Port CLK  input  1  the single clock; every register is clocked on its rising edge.
REQ-004 Port RST  input  1  reset, asynchronous and active-high.
REQ-005 Port KEY_IN  input  1  raw, asynchronous, bouncing push-button level.
REQ-006 Port SEL_IN  input  1  raw, asynchronous, bouncing mode-select switch level.
REQ-007 Port KEY_P  output  1  one-cycle strobe per accepted KEY press; drives the KEY input of the flash datapath.
REQ-008 Port SEL_OUT  output  1  debounced SEL level; drives the SEL input of the flash datapath.
REQ-009 Port TICK  output  1  one-cycle flash-rate enable for the flash datapath.

Function
REQ-010 KEY_IN and SEL_IN shall each pass through a two-flop synchronizer before any other logic, giving 2 cycles of latency.
REQ-011 Each synchronized input shall feed its own debounce FSM with states REL, PWAIT, PRS and RWAIT, plus a counter of width clog2(DEB_CYCLES)+1.
REQ-012 In REL, a sample of 1 shall move the FSM to PWAIT and clear the counter; a sample of 0 shall hold it in REL.
REQ-013 In PWAIT, a sample of 0 shall return the FSM to REL; a sample of 1 with counter equal to DEB_CYCLES-1 shall move it to PRS; any other sample of 1 shall increment the counter.
REQ-014 In PRS, a sample of 0 shall move the FSM to RWAIT and clear the counter; a sample of 1 shall hold it in PRS.
REQ-015 In RWAIT, a sample of 1 shall return the FSM to PRS; a sample of 0 with counter equal to DEB_CYCLES-1 shall move it to REL; any other sample of 0 shall increment the counter.
REQ-016 KEY_P shall be asserted, registered, for exactly the one cycle after the key FSM makes its PWAIT to PRS transition, giving one strobe per press regardless of hold time.
REQ-017 SEL_OUT shall be registered and equal to 1 exactly while the SEL FSM is in PRS or RWAIT.
REQ-018 With DEB_CYCLES=1, PWAIT shall resolve on the first sample; a pulse shorter than DEB_CYCLES synchronized cycles shall produce no KEY_P and no SEL_OUT change.
REQ-019 A free-running prescaler shall count 0 to TICK_DIV-1 and wrap to 0; TICK shall be asserted, registered, for one cycle when the count equals TICK_DIV-1.
REQ-020 In any cycle where KEY_P is asserted, the prescaler shall load 0 so that blink phase aligns to the key press.
REQ-021 If a KEY_P load and a prescaler wrap coincide, the load shall win and TICK shall be suppressed for that wrap.
REQ-022 The total latency from the first CLK edge that samples KEY_IN=1 to the assertion of KEY_P shall be DEB_CYCLES+3 cycles.

Reset
REQ-023 While RST is high, both FSMs shall be in REL, all counters and synchronizer flops shall be 0, and KEY_P, SEL_OUT and TICK shall be 0.
REQ-024 Asserting RST mid-debounce or mid-press shall abort the operation with no KEY_P emitted; after RST is released, an input held at 1 shall be re-debounced from REL.

Structure
REQ-025 The debounce state encoding (REL=2'd0, PWAIT=2'd1, PRS=2'd2, RWAIT=2'd3) and the default DEB_CYCLES and TICK_DIV values shall reside in the shared package led_pkg.
REQ-026 The synchronizer and debounce FSM shall be one sub-module, led_debounce, instantiated twice; it shall output a level and a rise strobe.
REQ-027 The prescaler and the KEY_P alignment logic shall reside in led_flash_ctrl.

Verification (DEB_CYCLES=4, TICK_DIV=8)
REQ-028 Reset check: assert RST asynchronously between clock edges -> KEY_P, SEL_OUT and TICK read 0 immediately and remain 0 until release.
REQ-029 Held press: KEY_IN=1 for 30 cycles -> exactly one KEY_P, 7 cycles after the first sampling edge.
REQ-030 Glitch: KEY_IN=1 for 3 cycles -> no KEY_P; KEY_IN bouncing 1-0-1 then held -> one KEY_P, timed from the last rise.
REQ-031 Prescaler: TICK every 8 cycles free-running; KEY_P arriving at prescaler count 5 -> next TICK 8 cycles after KEY_P; KEY_P coinciding with count 7 -> that TICK is absent.
REQ-032 SEL debounce: SEL_IN held at 1 -> SEL_OUT rises after 7 cycles; a 2-cycle dropout -> SEL_OUT stays 1; release held -> SEL_OUT falls 7 cycles later.
REQ-033 Reset mid-press: RST asserted while the key FSM is in PWAIT with KEY_IN still 1, then released -> no stale KEY_P, and one KEY_P 7 cycles after release.
